// File: rtl/conv1d_pe_stream_if.sv
// Row-in / window-out bus of the 1-D sliding-window PE.
//   slave  : the PE side (takes rows, produces window results)
//   master : the side that offers rows and consumes results
// Row channel   : in_valid/in_ready, mode, data_in, weight_in, psum_in
// Result channel: out_valid/out_ready, out_psum, out_idx, out_last
interface conv1d_pe_stream_if #(
  parameter int DATA_WIDTH = 8,
  parameter int INPUT_SIZE = 28,
  parameter int ACC_WIDTH  = 20
);
  localparam int IDX_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;

  logic                               in_valid;
  logic                               in_ready;
  logic                               mode;
  logic [INPUT_SIZE*DATA_WIDTH-1:0]   data_in;
  logic [INPUT_SIZE*DATA_WIDTH-1:0]   weight_in;
  logic signed [ACC_WIDTH-1:0]        psum_in;
  logic                               out_valid;
  logic                               out_ready;
  logic signed [ACC_WIDTH-1:0]        out_psum;
  logic [IDX_W-1:0]                   out_idx;
  logic                               out_last;

  modport master (
    output in_valid, mode, data_in, weight_in, psum_in, out_ready,
    input  in_ready, out_valid, out_psum, out_idx, out_last
  );

  modport slave (
    input  in_valid, mode, data_in, weight_in, psum_in, out_ready,
    output in_ready, out_valid, out_psum, out_idx, out_last
  );
endinterface

// File: rtl/conv1d_pe_stream.sv
// 1-D sliding-window processing element.
// Captures one data row, one weight row, a bias and a mode, then streams one
// signed window dot product (plus bias) per cycle over a valid/ready port.
//   mode 0: stride 1, shared kernel wt[0..K-1]
//   mode 1: stride K, per-segment weights, elements past the row read as 0
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  conv1d_pe_stream_if slave (row channel in, result channel out)
module conv1d_pe_stream #(
  parameter int DATA_WIDTH  = 8,
  parameter int INPUT_SIZE  = 28,
  parameter int KERNEL_SIZE = 3,
  parameter int ACC_WIDTH   = 20
) (
  input logic              clk,
  input logic              rst,
  conv1d_pe_stream_if.slave bus
);
  localparam int IDX_W  = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int N_OUT0 = INPUT_SIZE - KERNEL_SIZE + 1;
  localparam int N_OUT1 = (INPUT_SIZE + KERNEL_SIZE - 1) / KERNEL_SIZE;
  localparam logic [IDX_W-1:0] LAST0 = IDX_W'(N_OUT0 - 1);
  localparam logic [IDX_W-1:0] LAST1 = IDX_W'(N_OUT1 - 1);
  localparam int PW = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state, state_nxt;

  logic signed [DATA_WIDTH-1:0] d_q  [INPUT_SIZE];
  logic signed [DATA_WIDTH-1:0] wt_q [INPUT_SIZE];
  logic signed [ACC_WIDTH-1:0]  bias_q;
  logic                         mode_q;
  logic [IDX_W-1:0]             w_q;
  logic [IDX_W-1:0]             last_idx;
  int unsigned                  w_ext;

  logic                         out_valid_q;
  logic signed [ACC_WIDTH-1:0]  out_psum_q;
  logic [IDX_W-1:0]             out_idx_q;
  logic                         out_last_q;

  logic                         in_ready;
  logic                         accept;
  logic                         advance;
  logic                         w_is_last;

  logic signed [DATA_WIDTH-1:0] dv, wv;
  logic signed [PW-1:0]         prod;
  logic signed [ACC_WIDTH-1:0]  win_sum;

  assign last_idx  = mode_q ? LAST1 : LAST0;
  assign w_ext     = 32'(w_q);
  assign w_is_last = (w_q == last_idx);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.in_valid)           state_nxt = RUN;
      RUN:     if (advance && w_is_last)   state_nxt = DRAIN;
      DRAIN:   if (bus.out_ready)          state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready = (state == IDLE);
    accept   = in_ready && bus.in_valid;
    advance  = !out_valid_q || bus.out_ready;
  end

  // Row capture; contents are don't-care until the next acceptance
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      for (int unsigned i = 0; i < INPUT_SIZE; i++) begin
        d_q[i]  <= bus.data_in[i*DATA_WIDTH +: DATA_WIDTH];
        wt_q[i] <= bus.weight_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
      bias_q <= bus.psum_in;
      mode_q <= bus.mode;
    end
  end

  // Window pointer
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept)
        w_q <= '0;
      else if (state == RUN && advance && !w_is_last)
        w_q <= w_q + IDX_W'(1);
    end
  end

  // Window w dot product; element selection is a compare-mux over the row so
  // that out-of-row taps in mode 1 simply match nothing and contribute 0.
  always_comb begin
    win_sum = bias_q;
    dv      = '0;
    wv      = '0;
    prod    = '0;
    for (int unsigned k = 0; k < KERNEL_SIZE; k++) begin
      dv = '0;
      wv = '0;
      for (int unsigned i = 0; i < INPUT_SIZE; i++) begin
        if (mode_q) begin
          if (i == w_ext * KERNEL_SIZE + k) begin
            dv = d_q[i];
            wv = wt_q[i];
          end
        end else begin
          if (i == w_ext + k) dv = d_q[i];
          if (i == k)         wv = wt_q[i];
        end
      end
      prod    = PW'(dv) * PW'(wv);
      win_sum = win_sum + ACC_WIDTH'(prod);
    end
  end

  // Result register
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_psum_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (advance) begin
            out_valid_q <= 1'b1;
            out_psum_q  <= win_sum;
            out_idx_q   <= w_q;
            out_last_q  <= w_is_last;
          end
        end
        DRAIN: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_psum_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_psum  = out_psum_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_conv1d_pe_stream.sv
// Bench for conv1d_pe_stream: two instances in lockstep (ACC 20 and ACC 16),
// scoreboard of expected windows filled at row acceptance, popped on handshake.
module tb_conv1d_pe_stream;
  localparam int DW    = 8;
  localparam int IS    = 28;
  localparam int K     = 3;
  localparam int ACC_A = 20;
  localparam int ACC_B = 16;
  localparam int IDX_W = $clog2(IS);

  typedef struct {
    logic signed [ACC_A-1:0] p20;
    logic signed [ACC_B-1:0] p16;
    logic [IDX_W-1:0]        idx;
    logic                    last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv1d_pe_stream_if #(.DATA_WIDTH(DW), .INPUT_SIZE(IS), .ACC_WIDTH(ACC_A)) if_a ();
  conv1d_pe_stream_if #(.DATA_WIDTH(DW), .INPUT_SIZE(IS), .ACC_WIDTH(ACC_B)) if_b ();

  conv1d_pe_stream #(.DATA_WIDTH(DW), .INPUT_SIZE(IS), .KERNEL_SIZE(K), .ACC_WIDTH(ACC_A))
    u_dut (.clk(clk), .rst(rst), .bus(if_a));
  conv1d_pe_stream #(.DATA_WIDTH(DW), .INPUT_SIZE(IS), .KERNEL_SIZE(K), .ACC_WIDTH(ACC_B))
    u_dut16 (.clk(clk), .rst(rst), .bus(if_b));

  assign if_b.in_valid  = if_a.in_valid;
  assign if_b.mode      = if_a.mode;
  assign if_b.data_in   = if_a.data_in;
  assign if_b.weight_in = if_a.weight_in;
  assign if_b.psum_in   = ACC_B'(if_a.psum_in);
  assign if_b.out_ready = if_a.out_ready;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  int   m_d [IS];
  int   m_wt[IS];
  int   m_bias;
  logic m_mode;

  logic bp_en = 1'b0;
  logic s_valid, s_in_ready, s_acc;
  logic [IDX_W-1:0] s_idx;

  logic                    stalled = 1'b0;
  logic signed [ACC_A-1:0] h_psum;
  logic [IDX_W-1:0]        h_idx;
  logic                    h_last;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic logic signed [63:0] model(input int w);
    longint s;
    int     di, wi;
    s = m_bias;
    for (int k = 0; k < K; k++) begin
      di = m_mode ? w * K + k : w + k;
      wi = m_mode ? di : k;
      if (di < IS) s += longint'(m_d[di]) * longint'(m_wt[wi]);
    end
    return s;
  endfunction

  task automatic monitor();
    exp_t e;
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", if_a.out_valid, 1);
        chk("stall_psum",  if_a.out_psum,  h_psum);
        chk("stall_idx",   if_a.out_idx,   h_idx);
        chk("stall_last",  if_a.out_last,  h_last);
      end
      if (!if_a.out_valid) chk("idle_psum_zero", if_a.out_psum, 0);
      chk("lockstep_valid", if_b.out_valid, if_a.out_valid);
      checks++;
      assert (!(if_a.in_ready && if_a.out_valid)) else begin
        errors++;
        $error("FAIL ready_while_busy: in_ready=%0b out_valid=%0b required not both 1",
               if_a.in_ready, if_a.out_valid);
      end
      if (if_a.out_valid && if_a.out_ready) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL extra_output: idx=%0d observed with empty scoreboard, expected none", if_a.out_idx);
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("psum_acc20", if_a.out_psum, e.p20);
          chk("psum_acc16", if_b.out_psum, e.p16);
          chk("idx",        if_a.out_idx,  e.idx);
          chk("last",       if_a.out_last, e.last);
        end
      end
      stalled = if_a.out_valid && !if_a.out_ready;
      h_psum  = if_a.out_psum;
      h_idx   = if_a.out_idx;
      h_last  = if_a.out_last;
    end
  endtask

  // Every wait goes through here: sample+check at negedge, then resume #1 after posedge
  task automatic step();
    @(negedge clk);
    s_valid    = if_a.out_valid;
    s_in_ready = if_a.in_ready;
    s_idx      = if_a.out_idx;
    s_acc      = if_a.in_valid && if_a.in_ready;
    monitor();
    @(posedge clk);
    #1;
    if (bp_en) if_a.out_ready = ~if_a.out_ready;
  endtask

  task automatic send_row();
    logic             ok;
    int               n;
    exp_t             e;
    logic signed [63:0] s;
    for (int i = 0; i < IS; i++) begin
      if_a.data_in[i*DW +: DW]   = m_d[i][DW-1:0];
      if_a.weight_in[i*DW +: DW] = m_wt[i][DW-1:0];
    end
    if_a.psum_in  = ACC_A'(m_bias);
    if_a.mode     = m_mode;
    if_a.in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      step();
      if (s_acc) ok = 1'b1;
    end
    if_a.in_valid = 1'b0;
    chk("row_accepted", ok, 1);
    n = m_mode ? (IS + K - 1) / K : IS - K + 1;
    for (int w = 0; w < n; w++) begin
      s      = model(w);
      e.p20  = s[ACC_A-1:0];
      e.p16  = s[ACC_B-1:0];
      e.idx  = w[IDX_W-1:0];
      e.last = (w == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input int vc_start, output int vc);
    int n;
    vc = vc_start;
    n  = 0;
    while (!(exp_q.size() == 0 && !s_valid) && n < 300) begin
      step();
      n++;
      if (s_valid) vc++;
    end
    chk("drain_complete", exp_q.size(), 0);
    chk("in_ready_after_row", s_in_ready, 1);
  endtask

  task automatic set_ramp();
    for (int i = 0; i < IS; i++) begin
      m_d[i]  = i;
      m_wt[i] = (i < 3) ? 1 : 0;
    end
    m_bias = 0;
    m_mode = 1'b0;
  endtask

  task automatic set_const(input int dv, input int wv, input int b, input logic md);
    for (int i = 0; i < IS; i++) begin
      m_d[i]  = dv;
      m_wt[i] = wv;
    end
    m_bias = b;
    m_mode = md;
  endtask

  initial begin
    int   vc;
    logic found;

    rst            = 1'b1;
    if_a.in_valid  = 1'b0;
    if_a.mode      = 1'b0;
    if_a.data_in   = '0;
    if_a.weight_in = '0;
    if_a.psum_in   = '0;
    if_a.out_ready = 1'b1;
    s_valid        = 1'b0;
    s_in_ready     = 1'b0;
    s_idx          = '0;
    s_acc          = 1'b0;

    // Reset held for two edges
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_in_ready",  if_a.in_ready,  1);
    chk("rst_out_valid", if_a.out_valid, 0);
    chk("rst_out_psum",  if_a.out_psum,  0);
    chk("rst_out_idx",   if_a.out_idx,   0);
    chk("rst_out_last",  if_a.out_last,  0);
    chk("rst_b_valid",   if_b.out_valid, 0);
    rst = 1'b0;

    // Mode 0 ramp: latency then 26 back-to-back windows
    set_ramp();
    send_row();
    step();
    chk("lat_valid_t0",    s_valid,    0);
    chk("lat_in_ready_t0", s_in_ready, 0);
    step();
    chk("lat_valid_t1", s_valid, 1);
    chk("lat_idx_t1",   s_idx,   0);
    wait_done(1, vc);
    chk("ramp_valid_cycles", vc, 26);

    // Mode 1 with zero pad; inputs scrambled after acceptance must be ignored
    set_const(1, 2, -5, 1'b1);
    send_row();
    for (int i = 0; i < IS; i++) begin
      if_a.data_in[i*DW +: DW]   = DW'($urandom);
      if_a.weight_in[i*DW +: DW] = DW'($urandom);
    end
    if_a.psum_in = ACC_A'($urandom);
    if_a.mode    = 1'b0;
    wait_done(0, vc);
    chk("seg_valid_cycles", vc, 10);

    // Backpressure: out_ready toggles every cycle
    set_ramp();
    bp_en = 1'b1;
    send_row();
    wait_done(0, vc);
    bp_en          = 1'b0;
    if_a.out_ready = 1'b1;

    // Signed extremes: 3 * 16384 = 49152, wraps to -16384 at 16 bits
    set_const(-128, -128, 0, 1'b0);
    send_row();
    wait_done(0, vc);
    chk("extreme_valid_cycles", vc, 26);

    // Reset in the middle of a row
    set_ramp();
    send_row();
    found = 1'b0;
    for (int t = 0; t < 60 && !found; t++) begin
      step();
      if (if_a.out_valid && if_a.out_idx == 5) found = 1'b1;
    end
    chk("reached_idx5", found, 1);
    rst = 1'b1;
    step();
    chk("midrst_out_valid", if_a.out_valid, 0);
    chk("midrst_in_ready",  if_a.in_ready,  1);
    chk("midrst_out_psum",  if_a.out_psum,  0);
    chk("midrst_b_valid",   if_b.out_valid, 0);
    rst = 1'b0;
    exp_q.delete();

    set_const(1, 2, -5, 1'b1);
    send_row();
    step();
    step();
    chk("restart_valid", s_valid, 1);
    chk("restart_idx",   s_idx,   0);
    wait_done(1, vc);
    chk("restart_valid_cycles", vc, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
